// File: rtl/high_score_table_if.sv
// Bundle of control, insert handshake and read-port signals
// between the high-score table and its client.
interface high_score_table_if #(
  parameter int DATA_W = 14,
  parameter int ADDR_W = 4
);
  logic              clear;
  logic              insert_req;
  logic [DATA_W-1:0] insert_score;
  logic              insert_ready;
  logic              insert_done;
  logic              insert_accepted;
  logic [ADDR_W-1:0] insert_rank;
  logic [ADDR_W-1:0] read_addr;
  logic [DATA_W-1:0] read_data;
  logic [ADDR_W-1:0] count;

  modport master (
    output clear, insert_req, insert_score, read_addr,
    input  insert_ready, insert_done, insert_accepted,
    input  insert_rank, read_data, count
  );

  modport slave (
    input  clear, insert_req, insert_score, read_addr,
    output insert_ready, insert_done, insert_accepted,
    output insert_rank, read_data, count
  );
endinterface

// File: rtl/high_score_table.sv
// Descending-sorted top-N score table: search, shift-down, insert,
// with a registered random-access read port.
module high_score_table #(
  parameter int DATA_W = 14,
  parameter int DEPTH  = 14,
  parameter int ADDR_W = 4
) (
  input  logic clk,
  input  logic reset,
  high_score_table_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE, SEARCH, SHIFT, WRITE, DONE
  } state_e;

  localparam logic [ADDR_W-1:0] DEPTH_A = ADDR_W'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_A  = ADDR_W'(DEPTH - 1);

  state_e            state_q;
  logic [DATA_W-1:0] s_q;
  logic [ADDR_W-1:0] idx_q;
  logic [ADDR_W-1:0] pos_q;
  logic [ADDR_W-1:0] j_q;
  logic [ADDR_W-1:0] count_q;
  logic [DATA_W-1:0] rd_q;
  logic              done_q;
  logic              acc_q;
  logic [ADDR_W-1:0] rank_q;

  logic [DATA_W-1:0] mem_q [DEPTH];

  logic              we;
  logic [ADDR_W-1:0] waddr;
  logic [DATA_W-1:0] wdata;
  logic [ADDR_W-1:0] cmin;
  logic              accept;

  // last slot that can receive a shifted entry
  assign cmin   = (count_q < LAST_A) ? count_q : LAST_A;
  assign accept = bus.insert_req && (state_q == IDLE);

  assign bus.insert_ready    = (state_q == IDLE);
  assign bus.insert_done     = done_q;
  assign bus.insert_accepted = acc_q;
  assign bus.insert_rank     = rank_q;
  assign bus.read_data       = rd_q;
  assign bus.count           = count_q;

  always_comb begin
    we    = 1'b0;
    waddr = j_q;
    wdata = mem_q[j_q - 1'b1];
    if (state_q == SHIFT) begin
      we = 1'b1;
    end else if (state_q == WRITE) begin
      we    = 1'b1;
      waddr = pos_q;
      wdata = s_q;
    end
  end

  // storage is intentionally left uncleared on reset
  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      s_q     <= '0;
      idx_q   <= '0;
      pos_q   <= '0;
      j_q     <= '0;
      count_q <= '0;
      rd_q    <= '0;
      done_q  <= 1'b0;
      acc_q   <= 1'b0;
      rank_q  <= '0;
    end else begin
      done_q <= 1'b0;
      rd_q   <= (bus.read_addr < count_q)
                ? mem_q[bus.read_addr] : '0;
      unique case (state_q)
        IDLE: begin
          if (accept) begin
            s_q     <= bus.insert_score;
            idx_q   <= '0;
            state_q <= SEARCH;
          end else if (bus.clear) begin
            count_q <= '0;
          end
        end
        SEARCH: begin
          if (idx_q == count_q && count_q < DEPTH_A) begin
            pos_q   <= idx_q;
            j_q     <= cmin;
            state_q <= (count_q > idx_q) ? SHIFT : WRITE;
          end else if (idx_q == DEPTH_A) begin
            acc_q   <= 1'b0;
            rank_q  <= '0;
            done_q  <= 1'b1;
            state_q <= DONE;
          end else if (s_q > mem_q[idx_q]) begin
            pos_q   <= idx_q;
            j_q     <= cmin;
            state_q <= (cmin > idx_q) ? SHIFT : WRITE;
          end else begin
            idx_q <= idx_q + 1'b1;
          end
        end
        SHIFT: begin
          j_q <= j_q - 1'b1;
          if (j_q == pos_q + 1'b1) state_q <= WRITE;
        end
        WRITE: begin
          count_q <= (count_q < DEPTH_A)
                     ? count_q + 1'b1 : DEPTH_A;
          acc_q   <= 1'b1;
          rank_q  <= pos_q;
          done_q  <= 1'b1;
          state_q <= DONE;
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_high_score_table.sv
// Bench for high_score_table: queue-based reference model,
// per-cycle compare process and directed insert scenarios.
module tb_high_score_table;

  localparam int DATA_W = 14;
  localparam int DEPTH  = 14;
  localparam int ADDR_W = 4;

  logic clk;
  logic reset;

  high_score_table_if #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W)
  ) ifc ();

  high_score_table #(
    .DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(ifc.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  int q[$];
  int snap[$];
  bit prev_rdy = 1'b0;
  int ra_prev = 0;
  int ra_next = 0;
  bit peek_en = 1'b0;
  int peek_addr = 0;

  task automatic chk(input string nm, input int act,
                     input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d",
               nm, act, exp);
    end
  endtask

  // Reference: a sorted list where a new score lands after
  // every entry it does not strictly beat.
  task automatic predict(input int sc, output bit acc,
                         output int pos, output int lat);
    int n;
    n = q.size();
    pos = n;
    for (int i = 0; i < n; i++) begin
      if (sc > q[i]) begin
        pos = i;
        break;
      end
    end
    acc = (pos < DEPTH);
    if (!acc) begin
      pos = 0;
      lat = DEPTH + 1;
    end else begin
      lat = pos + 1 + (((n < DEPTH - 1) ? n : DEPTH - 1) - pos) + 1;
      if (lat < pos + 2) lat = pos + 2;
    end
  endtask

  always @(negedge clk) begin
    if (ifc.insert_ready === 1'b1) begin
      chk("count", int'(ifc.count), q.size());
      chk("done_idle", int'(ifc.insert_done), 0);
      if (prev_rdy)
        chk("read", int'(ifc.read_data),
            (ra_prev < snap.size()) ? snap[ra_prev] : 0);
    end
    prev_rdy = (ifc.insert_ready === 1'b1);
    snap = q;
    ra_prev = peek_en ? peek_addr : ra_next;
    ifc.read_addr = ADDR_W'(ra_prev);
    ra_next = (ra_next + 1) % 16;
  end

  task automatic peek(input int a, input int exp);
    peek_addr = a;
    peek_en = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    chk($sformatf("peek%0d", a), int'(ifc.read_data), exp);
    peek_en = 1'b0;
  endtask

  task automatic do_insert(input int sc, input bit noise,
                           output int rank_o);
    bit eacc;
    int epos, elat, n, k;
    predict(sc, eacc, epos, elat);
    @(negedge clk);
    k = 0;
    while (ifc.insert_ready !== 1'b1 && k < 50) begin
      @(negedge clk);
      k++;
    end
    if (k >= 50) chk("ready_timeout", 0, 1);
    ifc.insert_req = 1'b1;
    ifc.insert_score = DATA_W'(sc);
    @(posedge clk);
    #1;
    if (noise) begin
      ifc.insert_score = DATA_W'(999);
      ifc.clear = 1'b1;
    end else begin
      ifc.insert_req = 1'b0;
    end
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (ifc.insert_done !== 1'b1 && n < 100);
    ifc.insert_req = 1'b0;
    ifc.clear = 1'b0;
    chk($sformatf("lat_%0d", sc), n, elat);
    chk($sformatf("acc_%0d", sc),
        int'(ifc.insert_accepted), int'(eacc));
    chk($sformatf("rank_%0d", sc), int'(ifc.insert_rank), epos);
    rank_o = int'(ifc.insert_rank);
    if (eacc) begin
      q.insert(epos, sc);
      if (q.size() > DEPTH) q.pop_back();
    end
  endtask

  task automatic do_clear();
    @(negedge clk);
    ifc.clear = 1'b1;
    @(posedge clk);
    #1;
    ifc.clear = 1'b0;
    q.delete();
  endtask

  initial begin
    int r;
    reset = 1'b1;
    ifc.clear = 1'b0;
    ifc.insert_req = 1'b0;
    ifc.insert_score = '0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;

    // 1: empty table after reset
    chk("ready_rst", int'(ifc.insert_ready), 1);
    chk("count_rst", int'(ifc.count), 0);
    for (int a = 0; a < DEPTH; a++) peek(a, 0);

    // 2: basic ordering
    do_insert(100, 1'b0, r); chk("rank100", r, 0);
    do_insert(50, 1'b0, r);  chk("rank50", r, 1);
    do_insert(75, 1'b0, r);  chk("rank75", r, 1);
    peek(0, 100); peek(1, 75); peek(2, 50);
    chk("count3", int'(ifc.count), 3);

    // 3: tie goes after the equal entry
    do_insert(75, 1'b0, r); chk("rank_tie", r, 2);
    peek(2, 75); peek(3, 50);
    chk("count4", int'(ifc.count), 4);

    // 4: full table, reject and drop
    do_clear();
    for (int v = 140; v >= 10; v -= 10) do_insert(v, 1'b0, r);
    chk("count_full", int'(ifc.count), 14);
    do_insert(5, 1'b0, r); chk("rank_rej", r, 0);
    chk("acc_rej", int'(ifc.insert_accepted), 0);
    peek(13, 10);
    do_insert(135, 1'b0, r); chk("rank135", r, 1);
    peek(1, 135); peek(13, 20);
    chk("model13", q[13], 20);

    // 5: ignored req/clear mid-insert, then clear
    do_clear();
    peek(0, 0);
    chk("count_clr", int'(ifc.count), 0);
    do_insert(60, 1'b0, r);
    do_insert(30, 1'b0, r);
    do_insert(45, 1'b1, r); chk("rank45", r, 1);
    repeat (3) @(negedge clk);
    chk("count_noise", int'(ifc.count), 3);
    peek(1, 45);

    // 6: reset during SHIFT
    @(negedge clk);
    ifc.insert_req = 1'b1;
    ifc.insert_score = DATA_W'(90);
    @(posedge clk);
    #1;
    ifc.insert_req = 1'b0;
    @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    chk("rst_count", int'(ifc.count), 0);
    chk("rst_ready", int'(ifc.insert_ready), 1);
    chk("rst_done", int'(ifc.insert_done), 0);
    q.delete();
    @(posedge clk);
    #1;
    reset = 1'b0;
    do_insert(42, 1'b0, r); chk("rank42", r, 0);
    peek(0, 42);

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/high_score_table.md
Name: high_score_table

Overview:
- Parametrised successor to the scores array.
- Maintains a descending-sorted top-N score table for the binary game.
- Accepts a new score via a request/ready handshake, finds its rank, shifts lower entries down one slot per clock, then inserts; when full, the lowest score is dropped.
- Provides a registered random-access read port for the display/VGA logic.

Parameters:
- DATA_W, 14: score width in bits.
- DEPTH, 14: number of table entries (2..256).
- ADDR_W, 4: index width; must satisfy 2^ADDR_W >= DEPTH+1.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high; clears control state.
- clear  in  1  empties the table (count to 0); honoured in IDLE only.
- insert_req  in  1  request to insert insert_score; accepted on an edge where insert_req=1 and insert_ready=1.
- insert_score  in  DATA_W  score to insert (unsigned); latched on acceptance.
- insert_ready  out  1  high only in IDLE.
- insert_done  out  1  one-cycle pulse when an insertion attempt completes.
- insert_accepted  out  1  valid with insert_done: 1 = inserted, 0 = rejected (table full, score too low).
- insert_rank  out  ADDR_W  valid with insert_done: slot written (0 = best); 0 when rejected.
- read_addr  in  ADDR_W  read index.
- read_data  out  DATA_W  registered: entry[read_addr] if read_addr < count, else 0.
- count  out  ADDR_W  number of valid entries, 0..DEPTH.

Behaviour:
- Reset: all outputs and status go to their reset values immediately and asynchronously.
  - State IDLE, count=0, read_data=0, insert_done=0, insert_accepted=0, insert_rank=0, insert_ready=1.
  - Table storage is not cleared. It is invisible because count=0.
- Ordering invariant: entry[0] >= entry[1] >= ... >= entry[count-1], unsigned compare.
- Ties: a new score equal to an existing score goes after it (strict > compare).
- FSM states: IDLE, SEARCH, SHIFT, WRITE, DONE.
- IDLE:
  - On accept: latch score into s, set idx=0, go to SEARCH.
  - Else if clear=1: count<=0.
  - If insert_req and clear are both high, insert takes priority and clear is ignored.
- SEARCH (one index tested per cycle):
  - If idx==count and count<DEPTH: pos=idx. Then SHIFT if count>pos, else WRITE.
  - Else if idx==DEPTH: rejected, go to DONE.
  - Else if s > entry[idx]: pos=idx. Then SHIFT if min(count,DEPTH-1) > pos, else WRITE.
  - Else: idx<=idx+1.
- SHIFT:
  - j starts at min(count,DEPTH-1).
  - Each cycle: entry[j]<=entry[j-1], j<=j-1. When j reaches pos+1, that move is the last one; next state is WRITE.
  - When count==DEPTH, the old entry[DEPTH-1] is overwritten, i.e. dropped.
- WRITE: entry[pos]<=s; count<=min(count+1,DEPTH); go to DONE.
- DONE:
  - insert_done=1 for this cycle only.
  - insert_accepted and insert_rank are registered and held until the next DONE.
  - Go to IDLE.
- Latency: insert_done is high in the cycle beginning (pos+1)+S+1 edges after the accepting edge, where S = number of shift moves. A reject takes DEPTH+1 edges.
- insert_req outside IDLE is ignored; no queueing.
- Read port:
  - read_data updates every edge from the current table, one-cycle latency.
  - Reads during SHIFT may return intermediate contents; consumers gate reads on insert_ready.
- Reset asserted mid-operation aborts the insert. The table is left partially shifted but empty (count=0).

Test Plan:
1. Reset, then read_addr=0..13 -> read_data=0 for all, count=0, insert_ready=1.
2. Insert 100, 50, 75 in turn -> ranks 0, 0 then 1... ranks 0,1,1 respectively; reads 100,75,50; count=3.
   - Latency check: first insert into the empty table gives insert_done exactly 2 edges after acceptance.
3. Tie: with {100,75,50}, insert 75 -> rank 2, table {100,75,75,50}, count=4.
4. Full table:
   - Fill with 140,130,...,10 (14 entries). Insert 5 -> insert_accepted=0, rank 0, count=14, table unchanged, done after 15 edges.
   - Then insert 135 -> rank 1, entry[13]=20, 10 dropped.
5. Hold insert_req=1 with insert_score=999 during a SHIFT -> no second insert; count grows by exactly 1. clear=1 mid-insert is ignored; clear=1 in IDLE -> count=0, reads 0.
6. Assert reset during SHIFT -> within the same cycle count=0, insert_ready=1, insert_done=0. A subsequent insert of 42 -> rank 0, read 42.

Correction to scenario 2: the ranks are 0, 1, 1 (100 → 0; 50 → 1; 75 → 1).
